// File: rtl/shader_loader.sv
// Host-side loader: streams load commands into the instruction/data RAM
// write port, then runs the core and reports status and run length.
module shader_loader #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int START_DELAY   = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WORD_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDRESS_WIDTH-1:0] ext_write_address,
  output logic [WORD_WIDTH-1:0]    ext_write_data,
  output logic                     ext_enable_write_inst,
  output logic                     ext_enable_write_data,
  output logic                     run,
  input  logic                     halted,
  input  logic                     exception,
  output logic                     busy,
  output logic                     done,
  output logic                     done_exception,
  output logic [31:0]              cycle_count
);

  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN_START,
    S_RUN_WAIT,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic                     tgt_data_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [13:0]              remain_q;
  logic [DW-1:0]            dly_q;
  logic                     in_ready_q, busy_q, run_q, done_q;
  logic                     we_inst_q, we_data_q, done_exc_q;
  logic [ADDRESS_WIDTH-1:0] waddr_q;
  logic [WORD_WIDTH-1:0]    wdata_q;
  logic [31:0]              cycle_count_q;

  logic       fire;
  logic [1:0] op;
  logic [13:0] cnt;

  assign fire = in_valid && in_ready_q;
  assign op   = in_data[31:30];
  assign cnt  = in_data[29:16];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          unique case (op)
            2'b01, 2'b10: if (cnt != '0) state_d = S_LOAD;
            2'b11:        state_d = S_RUN_START;
            default:      state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD:      if (fire && remain_q == 14'd1) state_d = S_IDLE;
      S_RUN_START: if (dly_q == DW'(START_DELAY - 1)) state_d = S_RUN_WAIT;
      S_RUN_WAIT:  if (halted || exception) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      tgt_data_q    <= 1'b0;
      addr_q        <= '0;
      remain_q      <= '0;
      dly_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      run_q         <= 1'b0;
      done_q        <= 1'b0;
      we_inst_q     <= 1'b0;
      we_data_q     <= 1'b0;
      done_exc_q    <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
      busy_q     <= (state_d != S_IDLE);
      run_q      <= (state_d == S_RUN_START) || (state_d == S_RUN_WAIT);
      done_q     <= (state_d == S_DONE);
      we_inst_q  <= 1'b0;
      we_data_q  <= 1'b0;
      if (run_q && cycle_count_q != '1)
        cycle_count_q <= cycle_count_q + 32'd1;
      unique case (state_q)
        S_IDLE: begin
          if (fire && op != 2'b00) begin
            if (op == 2'b11) begin
              cycle_count_q <= '0;
              done_exc_q    <= 1'b0;
              dly_q         <= '0;
            end else begin
              tgt_data_q <= op[1];
              addr_q     <= {in_data[ADDRESS_WIDTH-1:2], 2'b00};
              remain_q   <= cnt;
            end
          end
        end
        S_LOAD: begin
          if (fire) begin
            wdata_q   <= in_data;
            waddr_q   <= addr_q;
            we_inst_q <= !tgt_data_q;
            we_data_q <= tgt_data_q;
            addr_q    <= addr_q + ADDRESS_WIDTH'(4);
            remain_q  <= remain_q - 14'd1;
          end
        end
        S_RUN_START: dly_q <= dly_q + DW'(1);
        S_RUN_WAIT:  if (halted || exception) done_exc_q <= exception;
        default: ;
      endcase
    end
  end

  assign in_ready              = in_ready_q;
  assign busy                  = busy_q;
  assign run                   = run_q;
  assign done                  = done_q;
  assign done_exception        = done_exc_q;
  assign cycle_count           = cycle_count_q;
  assign ext_write_address     = waddr_q;
  assign ext_write_data        = wdata_q;
  assign ext_enable_write_inst = we_inst_q;
  assign ext_enable_write_data = we_data_q;

endmodule

// File: doc/shader_loader.md
Name: shader_loader

Overview:
- Host-side sequencer that drives the external load/run port of the shader top level.
- Consumes a valid/ready stream of 32-bit command and payload words.
- Turns load commands into word writes on the external instruction and data RAM write strobes.
- A run command raises run, waits for halted or exception, then reports completion status and elapsed cycle count.

Parameters:
- WORD_WIDTH, 32, width of stream words and RAM write data
- ADDRESS_WIDTH, 16, byte address width of the external write port
- START_DELAY, 2, cycles after run rises during which halted/exception are ignored (core leaving reset-halt state)

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- in_data  input  32  command/payload word
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data this cycle
- ext_write_address  output  16  byte address to RAM write port
- ext_write_data  output  32  write data
- ext_enable_write_inst  output  1  instruction RAM write strobe
- ext_enable_write_data  output  1  data RAM write strobe
- run  output  1  core run enable; low while loading
- halted  input  1  core halted
- exception  input  1  core exception
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse at end of run
- done_exception  output  1  last run ended by exception; held until next run command
- cycle_count  output  32  cycles run was high in last run; held until next run command

Behaviour:
- Clocking and reset:
  - One clock: clock. Reset: reset_n, asynchronous, active-low.
  - All outputs are 0 during reset, including run (drops immediately if reset mid-run) and in_ready.
  - State returns to IDLE on reset. A load in progress is abandoned; RAM contents already written stay as they are.
- Handshake:
  - A word transfers when in_valid && in_ready on a rising edge.
  - in_ready = 1 in IDLE and LOAD, 0 in all other states.
- Header word fields (accepted in IDLE):
  - [31:30] opcode: 00 NOP, 01 LOAD_INST, 10 LOAD_DATA, 11 RUN.
  - [29:16] count: payload words, 0..16383.
  - [15:0] base byte address; bits [1:0] forced to 0.
- States:
  - IDLE:
    - NOP: stay in IDLE.
    - LOAD_* with count 0: no-op, stay in IDLE.
    - LOAD_* with count>0: latch target, address and remaining count; go to LOAD.
    - RUN: count and address fields ignored; clear cycle_count and done_exception; go to RUN_START.
  - LOAD:
    - Each accepted payload word is registered. On the next cycle: ext_write_data = word, ext_write_address = current address, and exactly one enable (inst or data, per opcode) high for one cycle.
    - Address then advances by 4, wrapping modulo 2^16 (0xFFFC -> 0x0000).
    - Throughput is 1 word/cycle; bubbles on in_valid produce gaps with no strobe.
    - After the last payload word is accepted, go to IDLE; the final strobe occurs in the first IDLE cycle.
    - A header accepted in that same IDLE cycle is legal.
  - RUN_START:
    - run = 1. Stay START_DELAY cycles, ignoring halted/exception; then go to RUN_WAIT.
    - The run command can only be accepted with no strobe pending, since loads finish before IDLE accepts a header.
  - RUN_WAIT:
    - run = 1. On the first cycle halted or exception is sampled high, go to DONE.
    - done_exception = exception at that edge; exception wins if both are high.
  - DONE:
    - run = 0, done = 1 for exactly one cycle, then IDLE.
- Outputs and counters:
  - ext_enable_write_* are never asserted while run = 1.
  - cycle_count increments on every cycle run = 1, saturating at 0xFFFFFFFF.
  - Outside a write strobe, ext_write_address and ext_write_data hold their last values; enables are 0.
- No timeout: a core that never halts keeps run high until reset.

Test Plan:
- Instruction load: header 0x4003_0100, payload 0x11, 0x22, 0x33 on consecutive cycles -> ext_enable_write_inst pulses 3 consecutive cycles at addresses 0x0100, 0x0104, 0x0108 with matching data; data enable stays 0; in_ready stays 1.
- Data load with bubbles and misaligned base: header 0x8002_0203, payload words with in_valid low 2 cycles between -> strobes at 0x0200 and 0x0204, separated by 2 idle cycles; inst enable stays 0.
- Address wrap: LOAD_DATA count 2 at base 0xFFFC -> strobes at 0xFFFC then 0x0000.
- Run to halt: header 0xC000_0000, core model holds halted high (ignored) for 2 cycles, low for 10, then high -> run high 13 cycles, done single pulse, done_exception 0, cycle_count 13, in_ready 0 throughout.
- Run to exception: halted and exception both rise together -> done_exception 1. Then a NOP header -> no strobes and no run; status values unchanged.
- Reset mid-load and mid-run: reset_n low during LOAD (count 5, 2 words sent) and during RUN_WAIT -> run and enables drop to 0 asynchronously; after release, busy 0, in_ready 1, and the next header is decoded as a header.
